// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: brings PS/2 key strobes into the system clock domain, decodes
// scan codes and keeps the snake heading via a small turn queue consumed one
// entry per game tick. Also produces the pause level and the restart pulse.
module snake_dir_ctrl #(
  parameter int         DEPTH     = 2,
  parameter logic [1:0] RESET_DIR = 2'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_pressed,
  input  logic [7:0] last_pressed,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       paused,
  output logic       restart,
  output logic       key_accept,
  output logic [2:0] q_count
);

  localparam logic [2:0] DEPTH_C  = 3'(DEPTH);
  localparam logic [1:0] LAST_PTR = 2'(DEPTH - 1);

  // synchronizer, edge detect and captured scan code
  logic       r_kp_s1, r_kp_s2, r_kp_d;
  logic [7:0] r_code;
  logic       r_code_vld;
  logic       w_new_key;

  // turn queue; storage sized for the largest legal DEPTH
  logic [1:0] r_q [0:3];
  logic [1:0] r_head, r_tail;
  logic [2:0] r_count;

  // registered outputs
  logic [1:0] r_dir;
  logic       r_paused, r_restart, r_key_accept;

  // decode results for the captured code
  logic       w_is_dir, w_is_pause, w_is_rst;
  logic [1:0] w_key_dir;

  logic [1:0] w_tail_last, w_ref;
  logic       w_full, w_push, w_pop, w_flush;

  // next pointer, wrapping modulo DEPTH
  function automatic logic [1:0] f_nxt(input logic [1:0] p);
    return (p == LAST_PTR) ? 2'd0 : p + 2'd1;
  endfunction

  // two-flop synchronizer plus a delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kp_s1 <= 1'b0;
      r_kp_s2 <= 1'b0;
      r_kp_d  <= 1'b0;
    end else begin
      r_kp_s1 <= key_pressed;
      r_kp_s2 <= r_kp_s1;
      r_kp_d  <= r_kp_s2;
    end
  end

  assign w_new_key = r_kp_s2 & ~r_kp_d;

  // the bus is stable by the time the strobe has crossed, so a plain capture suffices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code     <= 8'h00;
      r_code_vld <= 1'b0;
    end else begin
      if (w_new_key) r_code <= last_pressed;
      r_code_vld <= w_new_key;
    end
  end

  // scan code decode, only meaningful in the cycle after capture
  always_comb begin
    w_is_dir   = 1'b0;
    w_is_pause = 1'b0;
    w_is_rst   = 1'b0;
    w_key_dir  = 2'd0;
    if (r_code_vld) begin
      case (r_code)
        8'h75, 8'h1D: begin w_is_dir = 1'b1; w_key_dir = 2'd0; end
        8'h74, 8'h23: begin w_is_dir = 1'b1; w_key_dir = 2'd1; end
        8'h72, 8'h1B: begin w_is_dir = 1'b1; w_key_dir = 2'd2; end
        8'h6B, 8'h1C: begin w_is_dir = 1'b1; w_key_dir = 2'd3; end
        8'h29:        w_is_pause = 1'b1;
        8'h5A:        w_is_rst   = 1'b1;
        default:      ;
      endcase
    end
  end

  // a new turn is compared against the last queued turn, or the live heading
  // when nothing is queued, so chained turns can never fold back on themselves
  always_comb begin
    w_tail_last = (r_tail == 2'd0) ? LAST_PTR : r_tail - 2'd1;
    w_ref       = (r_count != 3'd0) ? r_q[w_tail_last] : r_dir;
    w_full      = (r_count == DEPTH_C);
    w_push      = w_is_dir & ~r_paused & ~w_full &
                  (w_key_dir != w_ref) & (w_key_dir != (w_ref ^ 2'd2));
    w_pop       = tick & ~r_paused & (r_count != 3'd0);
    w_flush     = w_is_rst | (w_is_pause & ~r_paused);
  end

  // queue, heading, pause and pulse outputs; restart overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_q[i] <= 2'd0;
      r_head       <= 2'd0;
      r_tail       <= 2'd0;
      r_count      <= 3'd0;
      r_dir        <= RESET_DIR;
      r_paused     <= 1'b0;
      r_restart    <= 1'b0;
      r_key_accept <= 1'b0;
    end else begin
      r_restart    <= w_is_rst;
      r_key_accept <= w_push;
      if (w_is_rst) begin
        r_dir    <= RESET_DIR;
        r_paused <= 1'b0;
        r_head   <= 2'd0;
        r_tail   <= 2'd0;
        r_count  <= 3'd0;
      end else begin
        if (w_pop)      r_dir    <= r_q[r_head];
        if (w_is_pause) r_paused <= ~r_paused;
        if (w_flush) begin
          r_head  <= 2'd0;
          r_tail  <= 2'd0;
          r_count <= 3'd0;
        end else begin
          if (w_push) begin
            r_q[r_tail] <= w_key_dir;
            r_tail      <= f_nxt(r_tail);
          end
          if (w_pop) r_head <= f_nxt(r_head);
          case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: ;
          endcase
        end
      end
    end
  end

  assign dir        = r_dir;
  assign paused     = r_paused;
  assign restart    = r_restart;
  assign key_accept = r_key_accept;
  assign q_count    = r_count;

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Consumes the PS/2 receiver's key_pressed pulse and last_pressed scan code, which arrive from the PS/2 clock domain.
- Synchronizes them into the system clock domain and decodes the scan codes.
- Maintains the snake's heading through a small direction queue, applying one queued turn per game tick with the no-reversal rule enforced.
- Also generates the pause toggle and the restart pulse for the game FSM.

Parameters:
DEPTH, 2, direction queue entries (legal 1..4)
RESET_DIR, 2'd1, heading after reset/restart (0 up, 1 right, 2 down, 3 left)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
key_pressed  input  1  receiver strobe, PS/2 clock domain, high for one PS/2 clock period (>=2 clk cycles)
last_pressed  input  8  scan code from receiver, stable while key_pressed high and afterwards
tick  input  1  game step strobe, 1 clk cycle
dir  output  2  current heading, encoding per RESET_DIR
paused  output  1  game paused level
restart  output  1  1-cycle restart pulse
key_accept  output  1  1-cycle pulse: direction key pushed into queue
q_count  output  3  entries currently queued

Behaviour:
- Reset (async, rst_n=0) values:
  - sync flops 0, edge flop 0
  - dir=RESET_DIR, paused=0, restart=0, key_accept=0, q_count=0
  - queue pointers 0
- Input synchronization:
  - key_pressed passes through 2 flops, then rising-edge detect -> new_key (1 cycle).
  - last_pressed is captured into code_r in the new_key cycle; no other synchronization on the bus, since it is stable by construction.
  - Decode and act in the cycle after capture. Latency key_pressed rise -> key_accept/restart/paused change = 3-4 clk.
  - A key_pressed level held high produces exactly one new_key.
- Decode of code_r:
  - Up: 8'h75, 8'h1D. Right: 8'h74, 8'h23. Down: 8'h72, 8'h1B. Left: 8'h6B, 8'h1C.
  - 8'h29 toggles pause. 8'h5A is restart.
  - Any other code is ignored with no output change.
- Direction push:
  - The reference heading ref is the tail entry if q_count>0, else dir.
  - Reject the key if paused, if queue full (q_count==DEPTH), if new==ref, or if new==ref^2 (reversal).
  - Otherwise write at tail, q_count+1, key_accept=1 for one cycle.
- Tick:
  - If !paused and q_count>0: dir<=head, pop, q_count-1.
  - If paused or q_count==0: dir holds.
- Simultaneous push and tick, same cycle:
  - ref is evaluated on pre-pop state.
  - Pop and push both occur and q_count is unchanged.
  - If the queue was empty, only the push happens; the new entry applies on the next tick.
- Pause key:
  - paused<=~paused.
  - Entering pause flushes the queue (q_count=0); dir is retained.
- Restart key:
  - restart=1 for one cycle.
  - Same cycle: dir<=RESET_DIR, paused<=0, queue flushed.
  - A tick in that cycle is ignored.
- Pointers wrap modulo DEPTH. q_count never exceeds DEPTH and never underflows.
- Reset asserted mid-operation clears everything immediately. A key_pressed still high at deassertion after the sync fill counts as one new key; the bench must not require otherwise.

Test Plan:
- Reset, no keys, 5 ticks -> dir=1 throughout, q_count=0, key_accept never pulses.
- From dir=1: key 8'h72 (down) then tick -> key_accept pulse 3-4 clk after key_pressed rise, q_count=1; after tick dir=2, q_count=0.
- From dir=1: key 8'h6B (left, reversal) and key 8'h23 (right, duplicate) -> no key_accept, q_count stays 0, dir=1 after tick.
- From dir=1: keys 8'h75 (up), 8'h1C (left), 8'h72 (down) with no tick -> up, left accepted, q_count=2, down rejected as full. Tick twice -> dir 0 then 3.
- Key 8'h29 with 1 entry queued -> paused=1, q_count=0. Ticks hold dir. Direction key rejected. Second 8'h29 -> paused=0.
- Key 8'h5A while paused, dir=3, and a tick in the restart cycle -> restart single pulse, dir=1, paused=0, q_count=0. Assert rst_n=0 mid-sequence -> all outputs at reset values within the same cycle.
